uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the UART TX FIFO write port (tx_wdata/tx_wten) between two character sources:
//  the monitor (uart_send_char output) and a CPU console putchar path.
//  Arbitration is line-atomic: the grant is held until an LF is sent, or until the owner
//  stalls past a timeout. This stops monitor dumps and CPU prints interleaving mid-line.
//  Sits between the requesters and uart_if inside the UART monitor top.
// PARAMETERS
//  TIMEOUT  1024  idle cycles (owner valid low) before a held grant is released
//  TOW      10    width of timeout counter; must satisfy 2**TOW >= TIMEOUT
// PORTS
//  clk           in   1  system clock; the only clock
//  rst           in   1  reset, synchronous, active-high
//  mon_char      in   8  monitor character
//  mon_valid     in   1  monitor char valid; held with mon_char until accepted
//  mon_ready     out  1  monitor char accepted this cycle when mon_valid&mon_ready
//  cpu_char      in   8  CPU console character
//  cpu_valid     in   1  CPU char valid; held with cpu_char until accepted
//  cpu_ready     out  1  CPU char accepted this cycle when cpu_valid&cpu_ready
//  tx_wdata      out  8  character to TX FIFO
//  tx_wten       out  1  TX FIFO write strobe, one-cycle pulse per character
//  tx_fifo_full  in   1  TX FIFO full
//  owner         out  2  2'b00 idle, 2'b01 monitor, 2'b10 CPU
//  line_timeout  out  1  one-cycle pulse when a grant is released by timeout
// BEHAVIOUR
//  Reset values: state IDLE, owner=0, tx_wten=0, tx_wdata=8'h00, line_timeout=0,
//   counter=0, last_owner=CPU (the monitor wins the first tie).
//  FSM states: IDLE, MON, CPU. owner is the registered state encoding.
//  IDLE: mon_valid&cpu_valid -> grant the side != last_owner.
//   Only one side valid -> grant that side. Neither valid -> stay in IDLE.
//   Update last_owner on every grant.
//  Ready is combinational: mon_ready = (state==MON) & ~tx_fifo_full & ~tx_wten.
//   cpu_ready follows the same rule with state==CPU. Both readys are 0 in IDLE.
//  The ~tx_wten term forbids back-to-back writes, so at most one write issues every
//   2 cycles. One stale cycle of tx_fifo_full therefore never overruns the FIFO.
//  Accept (valid&ready) at cycle N: tx_wdata<=char and tx_wten<=1 at N+1.
//   tx_wten returns to 0 at N+2 unless another write is issued.
//   Each accepted char is written exactly once; no char is dropped or duplicated.
//  Grant latency: valid rises at cycle 0 in IDLE -> state=owner at 1 -> earliest accept
//   at 1 -> tx_wten at 2.
//  MON/CPU: accepting char 8'h0A -> IDLE at the next cycle.
//   The other requester can be granted one cycle after that.
//  Timeout counter: cleared on every accept and on entry to MON/CPU.
//   Increments each cycle the owner's valid is low; holds while valid is high but
//   blocked by tx_fifo_full.
//   At counter==TIMEOUT-1 with the owner's valid still low: go to IDLE and pulse
//   line_timeout for 1 cycle. The counter saturates and never wraps.
//  A non-owner's valid has no effect until IDLE. The non-owner's ready stays 0.
//  Accepting 8'h0D (CR) releases nothing; only LF ends a line.
//  rst mid-line, or with a tx_wten pending: all state returns to reset values at the
//   next edge. An accepted char whose tx_wten has not yet issued is discarded.
// TESTING
//  T1: monitor only, sends 41,0D,0A -> tx_wdata 41,0D,0A; wten gaps >=2 cycles;
//      owner 01 then 00 one cycle after the 0A accept.
//  T2: both valid right after reset -> monitor line "X\n" completes first; CPU line
//      "OK\n" (4F,4B,0A) follows; the next tie grants the monitor again.
//  T3: CPU mid-line (owner=10), monitor asserts valid -> mon_ready=0 until the CPU 0A
//      is accepted; the monitor is granted within 2 cycles.
//  T4: tx_fifo_full held 20 cycles mid-line -> no tx_wten and ready=0 throughout;
//      resumes afterwards; output sequence matches input with no loss or duplication.
//  T5: TIMEOUT=16, owner drops valid after 1 char -> owner=00 and line_timeout pulse
//      after 16 idle cycles; the waiting CPU is then granted.
//  T6: rst asserted during a CPU line with tx_wten high -> next cycle owner=00,
//      tx_wten=0, both readys 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: line-atomic arbitration of the UART TX FIFO write port between monitor and CPU
module uart_tx_arbiter #(
    parameter int TIMEOUT = 1024,
    parameter int TOW     = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] mon_char,
    input  logic       mon_valid,
    output logic       mon_ready,
    input  logic [7:0] cpu_char,
    input  logic       cpu_valid,
    output logic       cpu_ready,
    output logic [7:0] tx_wdata,
    output logic       tx_wten,
    input  logic       tx_fifo_full,
    output logic [1:0] owner,
    output logic       line_timeout
);
    typedef enum logic [1:0] {IDLE = 2'b00, MON = 2'b01, CPU = 2'b10} state_t;
    state_t         state;
    logic           last_cpu;
    logic [TOW-1:0] cnt;
    logic           own_valid;
    logic           accept;
    logic [7:0]     own_char;

    assign mon_ready = state == MON && !tx_fifo_full && !tx_wten;
    assign cpu_ready = state == CPU && !tx_fifo_full && !tx_wten;
    assign own_valid = state == MON ? mon_valid : state == CPU ? cpu_valid : 1'b0;
    assign own_char  = state == CPU ? cpu_char : mon_char;
    assign accept    = (mon_valid && mon_ready) || (cpu_valid && cpu_ready);
    assign owner     = state;

    // grant/release FSM, idle timeout and registered FIFO write
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_cpu     <= 1'b1;
            cnt          <= '0;
            tx_wten      <= 1'b0;
            tx_wdata     <= 8'h00;
            line_timeout <= 1'b0;
        end else begin
            tx_wten      <= accept;
            line_timeout <= 1'b0;
            if (accept)
                tx_wdata <= own_char;
            case (state)
                IDLE: begin
                    if (mon_valid && (!cpu_valid || last_cpu)) begin
                        state    <= MON;
                        last_cpu <= 1'b0;
                        cnt      <= '0;
                    end else if (cpu_valid) begin
                        state    <= CPU;
                        last_cpu <= 1'b1;
                        cnt      <= '0;
                    end
                end
                default: begin
                    if (accept) begin
                        cnt <= '0;
                        if (own_char == 8'h0A)
                            state <= IDLE;
                    end else if (!own_valid) begin
                        if (cnt == TOW'(TIMEOUT - 1)) begin
                            state        <= IDLE;
                            line_timeout <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a line-level model
module tb_uart_tx_arbiter;
    localparam int TIMEOUT = 16;
    localparam int TOW     = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] mon_char = 8'h00, cpu_char = 8'h00, tx_wdata;
    logic       mon_valid = 1'b0, cpu_valid = 1'b0, tx_fifo_full = 1'b0;
    logic       mon_ready, cpu_ready, tx_wten, line_timeout;
    logic [1:0] owner;

    uart_tx_arbiter #(.TIMEOUT(TIMEOUT), .TOW(TOW)) dut (
        .clk(clk), .rst(rst),
        .mon_char(mon_char), .mon_valid(mon_valid), .mon_ready(mon_ready),
        .cpu_char(cpu_char), .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
        .tx_wdata(tx_wdata), .tx_wten(tx_wten), .tx_fifo_full(tx_fifo_full),
        .owner(owner), .line_timeout(line_timeout)
    );

    always #5 clk = ~clk;

    int         checks = 0, errors = 0;
    logic [7:0] mq[$], cq[$], outq[$], expq[$];
    int         mon_pct = 100, cpu_pct = 100, full_pct = 0;
    bit         full_force = 1'b0;
    int         m_own, m_last, idle, to_seen, total;
    logic       m_wten, m_to;
    logic [7:0] m_data;

    task chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mon_valid = 1'b0;
        cpu_valid = 1'b0;
        tx_fifo_full = 1'b0;
        mq.delete();
        cq.delete();
        outq.delete();
        @(posedge clk);
        #1;
        m_own = 0; m_last = 2; idle = 0; m_wten = 1'b0; m_data = 8'h00; m_to = 1'b0; to_seen = 0;
        chk("rst_owner", 8'(owner), 8'h00);
        chk("rst_wten", 8'(tx_wten), 8'h00);
        chk("rst_wdata", tx_wdata, 8'h00);
        chk("rst_timeout", 8'(line_timeout), 8'h00);
        chk("rst_mon_ready", 8'(mon_ready), 8'h00);
        chk("rst_cpu_ready", 8'(cpu_ready), 8'h00);
        rst = 1'b0;
    endtask

    task automatic step();
        logic       hs_m, hs_c, exp_mr, exp_cr, ov;
        logic [7:0] ch;
        int         n_own;
        logic       n_to;
        if (!mon_valid) mon_valid = mq.size() > 0 && $urandom_range(1, 100) <= 32'(mon_pct);
        if (!cpu_valid) cpu_valid = cq.size() > 0 && $urandom_range(1, 100) <= 32'(cpu_pct);
        mon_char = mq.size() > 0 ? mq[0] : 8'h00;
        cpu_char = cq.size() > 0 ? cq[0] : 8'h00;
        tx_fifo_full = full_force || $urandom_range(1, 100) <= 32'(full_pct);
        #1;
        exp_mr = m_own == 1 && !tx_fifo_full && !m_wten;
        exp_cr = m_own == 2 && !tx_fifo_full && !m_wten;
        chk("mon_ready", 8'(mon_ready), 8'(exp_mr));
        chk("cpu_ready", 8'(cpu_ready), 8'(exp_cr));
        hs_m = mon_valid && exp_mr;
        hs_c = cpu_valid && exp_cr;
        ch = hs_m ? mon_char : cpu_char;
        n_own = m_own;
        n_to = 1'b0;
        if (m_own == 0) begin
            if (mon_valid && (!cpu_valid || m_last == 2)) begin n_own = 1; m_last = 1; idle = 0; end
            else if (cpu_valid) begin n_own = 2; m_last = 2; idle = 0; end
        end else begin
            ov = m_own == 1 ? mon_valid : cpu_valid;
            if (hs_m || hs_c) begin
                idle = 0;
                if (ch == 8'h0A) n_own = 0;
            end else if (!ov) begin
                idle++;
                if (idle == TIMEOUT) begin n_own = 0; n_to = 1'b1; idle = 0; end
            end
        end
        @(posedge clk);
        #1;
        if (hs_m) begin mq.delete(0); mon_valid = 1'b0; end
        if (hs_c) begin cq.delete(0); cpu_valid = 1'b0; end
        m_own = n_own;
        m_wten = hs_m || hs_c;
        if (m_wten) m_data = ch;
        m_to = n_to;
        chk("owner", 8'(owner), 8'(m_own));
        chk("tx_wten", 8'(tx_wten), 8'(m_wten));
        chk("tx_wdata", tx_wdata, m_data);
        chk("line_timeout", 8'(line_timeout), 8'(m_to));
        if (tx_wten) outq.push_back(tx_wdata);
        if (line_timeout) to_seen++;
    endtask

    task automatic run(input int limit);
        int n = 0;
        while ((mq.size() > 0 || cq.size() > 0 || m_wten || m_own != 0) && n < limit) begin
            step();
            n++;
        end
        chk("drain_in_budget", 8'(n < limit), 8'h01);
    endtask

    task automatic cmp_out(input string tag);
        chk({tag, "_len"}, 8'(outq.size()), 8'(expq.size()));
        for (int i = 0; i < expq.size(); i++)
            chk(tag, i < outq.size() ? outq[i] : 8'hxx, expq[i]);
        outq.delete();
    endtask

    initial begin
        do_reset();
        mq = '{8'h41, 8'h0D, 8'h0A};
        run(100);
        expq = '{8'h41, 8'h0D, 8'h0A};
        cmp_out("t1_seq");

        do_reset();
        mq = '{8'h58, 8'h0A};
        cq = '{8'h4F, 8'h4B, 8'h0A};
        run(100);
        expq = '{8'h58, 8'h0A, 8'h4F, 8'h4B, 8'h0A};
        cmp_out("t2_seq");
        mq = '{8'h4D, 8'h0A};
        cq = '{8'h43, 8'h0A};
        run(100);
        expq = '{8'h4D, 8'h0A, 8'h43, 8'h0A};
        cmp_out("t2_tie");

        do_reset();
        cq = '{8'h43, 8'h50, 8'h55, 8'h0A};
        repeat (4) step();
        chk("t3_cpu_owner", 8'(owner), 8'h02);
        mq = '{8'h4D, 8'h0A};
        run(100);
        expq = '{8'h43, 8'h50, 8'h55, 8'h0A, 8'h4D, 8'h0A};
        cmp_out("t3_seq");

        do_reset();
        mq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0A};
        repeat (3) step();
        full_force = 1'b1;
        repeat (20) step();
        full_force = 1'b0;
        run(100);
        expq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0A};
        cmp_out("t4_seq");

        do_reset();
        mq = '{8'h41};
        cq = '{8'h4F, 8'h0A};
        run(100);
        chk("t5_timeouts", 8'(to_seen), 8'h01);
        expq = '{8'h41, 8'h4F, 8'h0A};
        cmp_out("t5_seq");

        do_reset();
        cq = '{8'h48, 8'h49, 8'h0A};
        for (int n = 0; n < 20 && !(tx_wten && owner == 2'b10); n++) step();
        chk("t6_wten_cpu", 8'(tx_wten && owner == 2'b10), 8'h01);
        do_reset();

        mon_pct = 60;
        cpu_pct = 60;
        full_pct = 20;
        total = 0;
        for (int l = 0; l < 6; l++) begin
            int len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                mq.push_back(8'($urandom_range(32'h20, 32'h7E)));
                cq.push_back($urandom_range(0, 5) == 0 ? 8'h0D : 8'($urandom_range(32'h20, 32'h7E)));
            end
            mq.push_back(8'h0A);
            cq.push_back(8'h0A);
            total += 2 * (len + 1);
        end
        run(3000);
        chk("rand_count", 8'(outq.size()), 8'(total));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
